// File: rtl/qpd_normalizer.sv
// qpd_normalizer: averages batches of QPD samples and normalises the X/Y
// differences by the averaged SUM using two bit-serial restoring dividers.
//
//   state | meaning
//   IDLE  | waiting for a completed batch
//   LOAD  | latch magnitudes, signs, divisor and low-light flag
//   DIV   | one quotient bit per cycle, outputFracSize+1 cycles
//   DONE  | results presented, out_valid high
module qpd_normalizer #(
  parameter int inputBitSize   = 16,
  parameter int inputFracSize  = 15,
  parameter int outputBitSize  = 16,
  parameter int outputFracSize = 15,
  parameter int avgLog2        = 2,
  parameter int sumMin         = 328
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [inputBitSize-1:0]  XDIFF,
  input  logic signed [inputBitSize-1:0]  YDIFF,
  input  logic signed [inputBitSize-1:0]  SUM,
  input  logic                            in_valid,
  output logic signed [outputBitSize-1:0] x_norm,
  output logic signed [outputBitSize-1:0] y_norm,
  output logic signed [outputBitSize-1:0] sum_avg,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            low_light,
  output logic                            overrun
);

  localparam int IW = inputBitSize;
  localparam int OW = outputBitSize;
  localparam int OF = outputFracSize;
  localparam int AL = avgLog2;
  localparam int AW = IW + AL;
  localparam int RW = IW + 2;
  localparam int QW = OF + 1;
  localparam int CW = AL + 1;
  localparam int BW = $clog2(QW) + 1;
  localparam int WW = ((QW > OW) ? QW : OW) + 1;
  localparam int LW = ((AW > OW) ? AW : OW) + 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'((1 << AL) - 1);
  localparam logic [BW-1:0]        BIT_LAST = BW'(OF);
  localparam logic [WW-1:0]        Q_MAX    = (WW'(1) << (OW - 1)) - WW'(1);
  localparam logic signed [LW-1:0] OUT_MAX  = (LW'(1) << (OW - 1)) - LW'(1);
  localparam logic signed [LW-1:0] OUT_MIN  = -OUT_MAX - LW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t state, state_nxt;
  logic   start, div_last;

  logic signed [AW-1:0] acc_x, acc_y, acc_s;
  logic signed [AW-1:0] nxt_x, nxt_y, nxt_s;
  logic signed [AW-1:0] avg_x, avg_y, avg_s;
  logic [CW-1:0]        cnt;
  logic                 batch_last, fsm_free, batch_take, batch_drop, pending;

  logic [RW-1:0]        den, rem_x, rem_y, sh_x, sh_y, rem_x_nxt, rem_y_nxt;
  logic [QW-1:0]        q_x, q_y, q_x_nxt, q_y_nxt;
  logic [BW-1:0]        bit_cnt;
  logic                 neg_x, neg_y, low_q;
  logic signed [OW-1:0] sum_q;

  // magnitude of an average; averages always fit in IW signed bits
  function automatic logic [RW-1:0] mag(input logic signed [AW-1:0] v);
    logic [AW-1:0] a;
    a = v[AW-1] ? -v : v;
    return RW'(a[IW-1:0]);
  endfunction

  // saturate the quotient magnitude (never producing the most negative code) and apply sign
  function automatic logic signed [OW-1:0] to_out(input logic [QW-1:0] q, input logic neg);
    logic [WW-1:0] qw, m;
    qw = WW'(q);
    m  = (q[QW-1] || (qw > Q_MAX)) ? Q_MAX : qw;
    return neg ? -OW'(m) : OW'(m);
  endfunction

  function automatic logic signed [OW-1:0] clamp(input logic signed [AW-1:0] v);
    logic signed [LW-1:0] w;
    w = LW'(v);
    if (w > OUT_MAX)      w = OUT_MAX;
    else if (w < OUT_MIN) w = OUT_MIN;
    return OW'(w);
  endfunction

  assign nxt_x      = acc_x + AW'(XDIFF);
  assign nxt_y      = acc_y + AW'(YDIFF);
  assign nxt_s      = acc_s + AW'(SUM);
  assign batch_last = in_valid && (cnt == CNT_LAST);
  assign fsm_free   = (state == IDLE) && !pending;
  assign batch_take = batch_last && fsm_free;
  assign batch_drop = batch_last && !fsm_free;

  // accumulate samples; restart cleanly on the sample that closes a batch
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
      acc_s <= '0;
      cnt   <= '0;
    end else if (in_valid) begin
      if (cnt == CNT_LAST) begin
        acc_x <= '0;
        acc_y <= '0;
        acc_s <= '0;
        cnt   <= '0;
      end else begin
        acc_x <= nxt_x;
        acc_y <= nxt_y;
        acc_s <= nxt_s;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // hand completed batches to the FSM, or drop them and flag overrun when it is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      avg_x   <= '0;
      avg_y   <= '0;
      avg_s   <= '0;
    end else begin
      if (batch_take) begin
        pending <= 1'b1;
        avg_x   <= nxt_x >>> AL;
        avg_y   <= nxt_y >>> AL;
        avg_s   <= nxt_s >>> AL;
      end else if (start) begin
        pending <= 1'b0;
      end
      if (batch_drop) overrun <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and status outputs
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    div_last  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt = LOAD;
          start     = 1'b1;
        end
      end
      LOAD: state_nxt = DIV;
      DIV: begin
        if (bit_cnt == BIT_LAST) begin
          state_nxt = DONE;
          div_last  = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // one restoring step per divider; the first step is the unshifted integer-bit test
  always_comb begin
    sh_x      = (bit_cnt == '0) ? rem_x : (rem_x << 1);
    sh_y      = (bit_cnt == '0) ? rem_y : (rem_y << 1);
    rem_x_nxt = (sh_x >= den) ? (sh_x - den) : sh_x;
    rem_y_nxt = (sh_y >= den) ? (sh_y - den) : sh_y;
    q_x_nxt   = (q_x << 1) | QW'(sh_x >= den);
    q_y_nxt   = (q_y << 1) | QW'(sh_y >= den);
  end

  // divider datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      den       <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      q_x       <= '0;
      q_y       <= '0;
      bit_cnt   <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
      low_q     <= 1'b0;
      sum_q     <= '0;
      x_norm    <= '0;
      y_norm    <= '0;
      sum_avg   <= '0;
      low_light <= 1'b0;
    end else begin
      if (state == LOAD) begin
        rem_x   <= mag(avg_x);
        rem_y   <= mag(avg_y);
        neg_x   <= avg_x[AW-1];
        neg_y   <= avg_y[AW-1];
        den     <= RW'(avg_s[IW-1:0]);
        low_q   <= (int'(avg_s) < sumMin);
        sum_q   <= clamp(avg_s);
        q_x     <= '0;
        q_y     <= '0;
        bit_cnt <= '0;
      end else if (state == DIV) begin
        rem_x   <= rem_x_nxt;
        rem_y   <= rem_y_nxt;
        q_x     <= q_x_nxt;
        q_y     <= q_y_nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (div_last) begin
        x_norm    <= low_q ? '0 : to_out(q_x_nxt, neg_x);
        y_norm    <= low_q ? '0 : to_out(q_y_nxt, neg_y);
        sum_avg   <= sum_q;
        low_light <= low_q;
      end
    end
  end

endmodule

// File: tb/tb_qpd_normalizer.sv
// tb_qpd_normalizer: randomized and directed checks of qpd_normalizer against
// a floor-division reference model of batch averaging and normalisation.
module tb_qpd_normalizer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic signed [15:0] xd = '0, yd = '0, sd = '0;
  logic               iv = 1'b0;
  logic signed [15:0] x_norm, y_norm, sum_avg;
  logic               out_valid, busy, low_light, overrun;

  logic signed [15:0] xd0 = '0, yd0 = '0, sd0 = '0;
  logic               iv0 = 1'b0;
  logic signed [15:0] x0n, y0n, s0a;
  logic               ov0, busy0, ll0, or0;

  always #5 clk = ~clk;

  qpd_normalizer dut (
    .clk(clk), .reset(reset), .XDIFF(xd), .YDIFF(yd), .SUM(sd), .in_valid(iv),
    .x_norm(x_norm), .y_norm(y_norm), .sum_avg(sum_avg), .out_valid(out_valid),
    .busy(busy), .low_light(low_light), .overrun(overrun)
  );

  qpd_normalizer #(.avgLog2(0)) dut0 (
    .clk(clk), .reset(reset), .XDIFF(xd0), .YDIFF(yd0), .SUM(sd0), .in_valid(iv0),
    .x_norm(x0n), .y_norm(y0n), .sum_avg(s0a), .out_valid(ov0),
    .busy(busy0), .low_light(ll0), .overrun(or0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 1'b0;

  typedef struct {
    int due;
    int x;
    int y;
    int s;
    int ll;
  } exp_t;

  exp_t expq[$];
  int acc_x = 0, acc_y = 0, acc_s = 0, nsamp = 0;
  int last_acc = -1000;
  int hold_x = 0, hold_y = 0, hold_s = 0, hold_ll = 0, m_overrun = 0;
  int done_edge = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%h) required=%0d (0x%h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int r;
    r = a % b;
    if (r < 0) r += b;
    return (a - r) / b;
  endfunction

  function automatic int norm(input int a, input int s);
    int m, q;
    if (s < 328) return 0;
    m = (a < 0) ? -a : a;
    q = (m >= s) ? 32767 : (m * 32768) / s;
    return (a < 0) ? -q : q;
  endfunction

  // reference model: batches of 4, result 18 edges after the completing sample,
  // a batch is dropped if it completes within 20 edges of the last accepted one
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      started = 1'b1;
      expq.delete();
      acc_x = 0; acc_y = 0; acc_s = 0; nsamp = 0;
      last_acc = -1000;
      hold_x = 0; hold_y = 0; hold_s = 0; hold_ll = 0; m_overrun = 0;
    end else if (iv) begin
      acc_x += int'(xd);
      acc_y += int'(yd);
      acc_s += int'(sd);
      nsamp++;
      if (nsamp == 4) begin
        if (cyc - last_acc >= 20) begin
          e.due = cyc + 18;
          e.s   = fdiv(acc_s, 4);
          e.x   = norm(fdiv(acc_x, 4), e.s);
          e.y   = norm(fdiv(acc_y, 4), e.s);
          e.ll  = (e.s < 328) ? 1 : 0;
          expq.push_back(e);
          last_acc = cyc;
        end else begin
          m_overrun = 1;
        end
        acc_x = 0; acc_y = 0; acc_s = 0; nsamp = 0;
      end
    end
  end

  // compare every cycle against the model
  always @(negedge clk) begin
    int ev;
    if (started) begin
      ev = (expq.size() > 0 && expq[0].due == cyc) ? 1 : 0;
      chk("out_valid", int'(out_valid), ev);
      if (ev == 1) begin
        hold_x  = expq[0].x;
        hold_y  = expq[0].y;
        hold_s  = expq[0].s;
        hold_ll = expq[0].ll;
        void'(expq.pop_front());
      end
      chk("x_norm", int'(x_norm), hold_x);
      chk("y_norm", int'(y_norm), hold_y);
      chk("sum_avg", int'(sum_avg), hold_s);
      chk("low_light", int'(low_light), hold_ll);
      chk("overrun", int'(overrun), m_overrun);
      chk("busy", int'(busy), (cyc > last_acc && cyc <= last_acc + 18) ? 1 : 0);
    end
  end

  task automatic sample(input int x, input int y, input int s, input int gap);
    @(negedge clk);
    iv = 1'b1;
    xd = 16'(x);
    yd = 16'(y);
    sd = 16'(s);
    @(negedge clk);
    iv = 1'b0;
    done_edge = cyc;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic batch(input int x, input int y, input int s);
    repeat (4) sample(x, y, s, 1);
  endtask

  task automatic wait_result(input string nm, input int ex, input int ey, input int es, input int ell);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk({nm, "_valid"}, int'(out_valid), 1);
    if (out_valid) begin
      chk({nm, "_latency"}, cyc - done_edge, 18);
      chk({nm, "_x"}, int'(x_norm), ex);
      chk({nm, "_y"}, int'(y_norm), ey);
      chk({nm, "_sum"}, int'(sum_avg), es);
      chk({nm, "_ll"}, int'(low_light), ell);
    end
    @(negedge clk);
  endtask

  initial begin
    int pulses, seen_x, x, y, s, r;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_x_norm", int'(x_norm), 0);
    chk("rst_sum_avg", int'(sum_avg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);

    // back-to-back single-sample batches on the avgLog2=0 instance
    @(negedge clk);
    iv0 = 1'b1; xd0 = 16'h1000; yd0 = 16'h0000; sd0 = 16'h4000;
    @(negedge clk);
    xd0 = 16'h2000;
    @(negedge clk);
    iv0 = 1'b0;
    pulses = 0;
    seen_x = 0;
    repeat (40) begin
      if (ov0) begin
        pulses++;
        seen_x = int'(x0n);
      end
      @(negedge clk);
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_first_x", seen_x, 8192);
    chk("ovr_set", int'(or0), 1);
    repeat (30) @(negedge clk);
    chk("ovr_sticky", int'(or0), 1);

    batch(16'h1000, 16'hF000, 16'h4000);
    wait_result("basic", 8192, -8192, 16384, 0);
    batch(16'h5000, 16'hB000, 16'h4000);
    wait_result("sat", 32767, -32767, 16384, 0);
    batch(16'h4000, 16'h8000, 16'h4000);
    wait_result("sat_eq", 32767, -32767, 16384, 0);
    batch(16'h1000, 16'h1000, 16'h0100);
    wait_result("low_pos", 0, 0, 256, 1);
    batch(16'h1000, 16'h1000, 16'hFF00);
    wait_result("low_neg", 0, 0, -256, 1);
    batch(100, -100, 328);
    wait_result("thr_328", 9990, -9990, 328, 0);
    batch(100, -100, 327);
    wait_result("thr_327", 0, 0, 327, 1);
    sample(-1, 3, 16'h4000, 1);
    sample(0, 3, 16'h4000, 1);
    sample(0, 3, 16'h4000, 1);
    sample(0, 3, 16'h4001, 1);
    wait_result("floor", -2, 6, 16384, 0);

    // reset five cycles into the division, with a partial batch accumulated
    batch(16'h1000, 16'hF000, 16'h4000);
    sample(16'h7000, 16'h7000, 16'h0100, 1);
    sample(16'h7000, 16'h7000, 16'h0100, 1);
    repeat (2) @(negedge clk);
    chk("busy_in_div", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_x", int'(x_norm), 0);
    chk("abort_y", int'(y_norm), 0);
    chk("abort_sum", int'(sum_avg), 0);
    chk("abort_ll", int'(low_light), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovr0", int'(or0), 0);
    batch(16'h1000, 16'hF000, 16'h4000);
    wait_result("post_reset", 8192, -8192, 16384, 0);

    // random samples at spacing of at least 5 cycles
    repeat (60) begin
      for (int j = 0; j < 4; j++) begin
        x = int'($urandom_range(0, 65535));
        y = int'($urandom_range(0, 65535));
        r = int'($urandom_range(0, 7));
        if (r == 0)      s = int'($urandom_range(300, 360));
        else if (r == 1) s = int'($urandom_range(0, 65535));
        else             s = int'($urandom_range(2000, 32767));
        sample(x, y, s, int'($urandom_range(5, 8)));
      end
    end
    repeat (30) @(negedge clk);
    chk("rand_overrun", int'(overrun), 0);
    chk("rand_pending", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpd_normalizer.md
QPD_NORMALIZER -- requirements
Module: qpd_normalizer

Interface
REQ-001 SHALL have parameter inputBitSize, default 16, meaning the width of signed XDIFF/YDIFF/SUM samples.
REQ-002 SHALL have parameter inputFracSize, default 15, meaning the fractional bits of the input samples.
REQ-003 SHALL have parameter outputBitSize, default 16, meaning the width of signed x_norm/y_norm/sum_avg.
REQ-004 SHALL have parameter outputFracSize, default 15, meaning the fractional bits of x_norm/y_norm (sum_avg uses inputFracSize).
REQ-005 SHALL have parameter avgLog2, default 2, meaning log2 of the samples averaged per batch (0..4).
REQ-006 SHALL have parameter sumMin, default 328, meaning the signed SUM-average threshold below which the light is treated as too low.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 XDIFF  input  inputBitSize  signed QPD x-difference sample.
REQ-010 YDIFF  input  inputBitSize  signed QPD y-difference sample.
REQ-011 SUM  input  inputBitSize  signed QPD total-intensity sample.
REQ-012 in_valid  input  1  the three samples are valid this cycle.
REQ-013 x_norm  output  outputBitSize  signed average(XDIFF)/average(SUM).
REQ-014 y_norm  output  outputBitSize  signed average(YDIFF)/average(SUM).
REQ-015 sum_avg  output  outputBitSize  batch average of SUM, clamped to outputBitSize.
REQ-016 out_valid  output  1  one-cycle pulse; x_norm/y_norm/sum_avg are new.
REQ-017 busy  output  1  high while the divider FSM is not IDLE.
REQ-018 low_light  output  1  the last result had sum_avg < sumMin; updated with out_valid.
REQ-019 overrun  output  1  sticky; a completed batch was dropped; cleared only by reset.

Function
REQ-020 Accumulation SHALL be independent of the FSM: each in_valid adds the sign-extended samples into three accumulators of width inputBitSize+avgLog2, and a counter counts to 2^avgLog2.
REQ-021 On the in_valid that completes a batch, the averages (accumulator arithmetic-shifted right by avgLog2, rounding toward -inf) SHALL be computed, the accumulators and counter SHALL restart with the next sample, and the batch SHALL be handed to the FSM.
REQ-022 FSM states SHALL be IDLE, LOAD, DIV and DONE: IDLE->LOAD on a handed batch; LOAD->DIV after 1 cycle; DIV->DONE after exactly outputFracSize+1 cycles; DONE->IDLE after 1 cycle.
REQ-023 If a batch completes while the FSM is not IDLE, that batch SHALL be discarded, overrun SHALL be set, and the running division SHALL be unaffected.
REQ-024 Division SHALL be two parallel restoring dividers, one quotient bit per DIV cycle, computing q = floor(|num|*2^outputFracSize / den), with den = sum average and the sign of num applied afterwards.
REQ-025 If |num| >= den, the quotient SHALL saturate to +(2^(outputBitSize-1)-1) with the sign applied (e.g. 0x7FFF or 0x8001); 0x8000 SHALL never be produced.
REQ-026 If sum average < sumMin (signed comparison, so a negative SUM qualifies), x_norm and y_norm SHALL be 0 and low_light SHALL be 1; otherwise low_light SHALL be 0.
REQ-027 out_valid SHALL be high during DONE, i.e. exactly outputFracSize+3 cycles (18 at defaults) after the edge capturing the completing sample; outputs SHALL hold between pulses.
REQ-028 Throughput: at default parameters, a batch every 4 samples SHALL never overrun when samples arrive no more often than every 5 cycles.

Reset
REQ-029 Reset SHALL zero x_norm, y_norm, sum_avg, out_valid, busy, low_light, overrun, the accumulators and the counter, and SHALL put the FSM in IDLE.
REQ-030 Reset asserted mid-division SHALL abort the division with no out_valid; the first result after reset SHALL come only from samples received after reset.

Verification
REQ-031 Defaults; 4 samples XDIFF=0x1000, YDIFF=0xF000, SUM=0x4000 -> one out_valid 18 cycles after the 4th, x_norm=0x2000, y_norm=0xE000, sum_avg=0x4000, low_light=0.
REQ-032 Defaults; 4 samples XDIFF=0x5000, YDIFF=0xB000, SUM=0x4000 -> x_norm=0x7FFF, y_norm=0x8001.
REQ-033 Defaults; SUM=0x0100 (and a separate case with SUM=0xFF00) -> x_norm=y_norm=0, low_light=1.
REQ-034 avgLog2=0; in_valid on two consecutive cycles -> only the first result is produced, overrun=1 and stays 1 until reset.
REQ-035 Defaults; reset pulsed 5 cycles into DIV -> no out_valid; all outputs are 0; a fresh 4-sample batch then gives a correct result.
REQ-036 Random samples and spacing >= 5 cycles at defaults, checked against a floor-division reference model -> bit-exact match, overrun=0.
